// File: rtl/imem_boot_loader_pkg.sv
// Shared constants, state encoding and header check for the I-mem boot loader.
package imem_boot_loader_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int PC_W   = 8;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    // A header is legal when it names between 1 and DEPTH words.
    function automatic logic len_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(DEPTH));
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four accepted bytes MSB-first into one 32-bit word and flags the
// cycle on which the fourth byte arrives.
module imem_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_i,
    output logic              word_vld_o,
    output logic [DATA_W-1:0] word_o
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [23:0] shift_q;
    logic [23:0] shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (flush_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_vld_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // The fourth byte is taken straight from the input so the top can register
    // the finished word on the same edge it is accepted.
    assign word_vld_o = byte_vld_i && !flush_i && (cnt_q == 2'd3);
    assign word_o     = {shift_q, byte_i};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed image into I-mem, NOP-fills the tail,
// then releases the CPU and lets the PC address I-mem directly.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    input  logic [PC_W-1:0]   pc_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              imem_we,
    output logic              cpu_hold,
    output logic              cpu_pc_reset,
    output logic              load_done,
    output logic              err_len
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W:0]     nwords_q;
    logic [ADDR_W:0]     nwords_d;
    logic [ADDR_W:0]     word_idx_q;
    logic [ADDR_W:0]     word_idx_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wdata_d;
    logic                we_q;
    logic                we_d;
    logic                pc_reset_q;
    logic                pc_reset_d;
    logic                err_q;
    logic                err_d;

    logic                accept;
    logic                asm_flush;
    logic                asm_byte_vld;
    logic                word_vld;
    logic [DATA_W-1:0]   word;
    logic                last_word_wr;
    logic                unused_pc_lsbs;

    assign rx_ready     = (state_q == ST_HEADER) || (state_q == ST_LOAD);
    assign accept       = rx_valid && rx_ready;
    assign asm_flush    = (state_q != ST_LOAD);
    assign asm_byte_vld = accept && (state_q == ST_LOAD);

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (asm_flush),
        .byte_vld_i (asm_byte_vld),
        .byte_i     (rx_data),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

    // The final image word is on the write port this cycle; leave LOAD next edge.
    assign last_word_wr = we_q && ({1'b0, addr_q} == (nwords_q - {{ADDR_W{1'b0}}, 1'b1}));

    always_comb begin
        state_d    = state_q;
        nwords_d   = nwords_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        pc_reset_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_HEADER: begin
                if (accept) begin
                    if (len_ok(rx_data)) begin
                        nwords_d   = rx_data[ADDR_W:0];
                        word_idx_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end

            ST_LOAD: begin
                if (last_word_wr) begin
                    if (nwords_q < DEPTH_CNT) begin
                        state_d = ST_CLEAR;
                        we_d    = 1'b1;
                        addr_d  = nwords_q[ADDR_W-1:0];
                        wdata_d = NOP_WORD;
                    end else begin
                        state_d    = ST_RUN;
                        pc_reset_d = 1'b1;
                    end
                end else if (word_vld) begin
                    we_d       = 1'b1;
                    addr_d     = word_idx_q[ADDR_W-1:0];
                    wdata_d    = word;
                    word_idx_d = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
                end
            end

            ST_CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    pc_reset_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    wdata_d = NOP_WORD;
                end
            end

            ST_RUN: begin
                if (reload) begin
                    state_d    = ST_HEADER;
                    nwords_d   = '0;
                    word_idx_d = '0;
                    addr_d     = '0;
                end
            end

            ST_ERR: begin
                err_d = 1'b1;
            end

            default: begin
                state_d = ST_HEADER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HEADER;
            nwords_q   <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            pc_reset_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nwords_q   <= nwords_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            pc_reset_q <= pc_reset_d;
            err_q      <= err_d;
        end
    end

    // In RUN the PC drives the read address with no register in the path.
    assign imem_addr      = (state_q == ST_RUN) ? pc_addr[PC_W-1:2] : addr_q;
    assign imem_wdata     = wdata_q;
    assign imem_we        = we_q;
    assign cpu_hold       = (state_q != ST_RUN);
    assign load_done      = (state_q == ST_RUN);
    assign cpu_pc_reset   = pc_reset_q;
    assign err_len        = err_q;
    assign unused_pc_lsbs = ^pc_addr[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal, bad-length, full, reset and reload loads.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_ready;
    logic              reload   = 1'b0;
    logic [PC_W-1:0]   pc_addr  = '0;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              imem_we;
    logic              cpu_hold;
    logic              cpu_pc_reset;
    logic              load_done;
    logic              err_len;

    int checks_n = 0;
    int fails_n  = 0;

    imem_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .pc_addr      (pc_addr),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .imem_we      (imem_we),
        .cpu_hold     (cpu_hold),
        .cpu_pc_reset (cpu_pc_reset),
        .load_done    (load_done),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    // Write/event log sampled on the falling edge.
    int          cyc     = 0;
    logic        ld_prev = 1'b0;
    int          bad_we  = 0;
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          pcr_q[$];
    int          run_q[$];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        ld_prev <= load_done;
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end
        if (cpu_pc_reset === 1'b1) pcr_q.push_back(cyc);
        if (load_done === 1'b1 && ld_prev !== 1'b1) run_q.push_back(cyc);
        if (imem_we === 1'b1 && (load_done === 1'b1 || err_len === 1'b1)) bad_we <= bad_we + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fails_n++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 0);
        send_byte(w[23:16], 0);
        send_byte(w[15:8], 0);
        send_byte(w[7:0], 0);
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, load_done}, 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Checks a load of nw image words (first word w0) followed by the NOP tail.
    task automatic verify_load(input string tag, input int base, input int nw,
                               input logic [31:0] w0, input int pcr_base, input int run_base);
        int bad;
        chk({tag, "_wr_count"}, wa_q.size() - base, 32'd64);
        chk({tag, "_pcr_count"}, pcr_q.size() - pcr_base, 32'd1);
        chk({tag, "_run_count"}, run_q.size() - run_base, 32'd1);
        if (wa_q.size() - base >= 64 && pcr_q.size() > pcr_base && run_q.size() > run_base) begin
            chk({tag, "_w0_addr"}, 32'(wa_q[base]), 32'd0);
            chk({tag, "_w0_data"}, wd_q[base], w0);
            bad = 0;
            for (int i = nw; i < 64; i++) begin
                if (wa_q[base+i] !== 6'(i) || wd_q[base+i] !== 32'h0 ||
                    wc_q[base+i] != wc_q[base+i-1] + 1) bad++;
            end
            chk({tag, "_clear_seq_bad"}, bad, 32'd0);
            chk({tag, "_run_after_last_wr"}, run_q[run_base], wc_q[base+63] + 1);
            chk({tag, "_pcr_on_run_entry"}, pcr_q[pcr_base], run_q[run_base]);
        end
    endtask

    function automatic logic [7:0] img_byte(input int k);
        return 8'(k * 37 + 11);
    endfunction

    initial begin
        int base, pb, rb, bad;
        logic [31:0] exp_w;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_pc_reset", {31'd0, cpu_pc_reset}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_err_len", {31'd0, err_len}, 32'd0);
        reset = 1'b0;
        #1;

        // Normal two-word load
        base = wa_q.size(); pb = pcr_q.size(); rb = run_q.size();
        send_byte(8'h02, 0);
        send_word(32'h2008_0020);
        send_word(32'h2009_0037);
        wait_run("t1_run_reached");
        verify_load("t1", base, 2, 32'h2008_0020, pb, rb);
        if (wa_q.size() - base >= 2) begin
            chk("t1_w1_addr", 32'(wa_q[base+1]), 32'd1);
            chk("t1_w1_data", wd_q[base+1], 32'h2009_0037);
        end
        chk("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t1_rx_ready", {31'd0, rx_ready}, 32'd0);

        // Bad header lengths
        do_reset();
        base = wa_q.size();
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk);
        chk("t2a_err_len", {31'd0, err_len}, 32'd1);
        chk("t2a_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("t2a_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2a_err_after_reload", {31'd0, err_len}, 32'd1);
        chk("t2a_ready_after_reload", {31'd0, rx_ready}, 32'd0);
        do_reset();
        chk("t2_err_cleared", {31'd0, err_len}, 32'd0);
        send_byte(8'h41, 0);
        repeat (3) @(negedge clk);
        chk("t2b_err_len", {31'd0, err_len}, 32'd1);
        chk("t2b_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("t2b_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        #1;
        chk("t2_no_writes", wa_q.size() - base, 32'd0);

        // Full 64-word image with random valid gaps
        do_reset();
        base = wa_q.size(); pb = pcr_q.size(); rb = run_q.size();
        send_byte(8'h40, 0);
        for (int k = 0; k < 256; k++) send_byte(img_byte(k), $urandom_range(0, 2));
        wait_run("t3_run_reached");
        exp_w = {img_byte(0), img_byte(1), img_byte(2), img_byte(3)};
        verify_load("t3", base, 64, exp_w, pb, rb);
        if (wa_q.size() - base >= 64) begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                exp_w = {img_byte(4*i), img_byte(4*i+1), img_byte(4*i+2), img_byte(4*i+3)};
                if (wa_q[base+i] !== 6'(i) || wd_q[base+i] !== exp_w) bad++;
            end
            chk("t3_image_bad_words", bad, 32'd0);
        end

        // RUN address mux
        @(negedge clk);
        pc_addr = 8'h0C;
        #1;
        chk("t4_addr_0c", 32'(imem_addr), 32'd3);
        chk("t4_we_0c", {31'd0, imem_we}, 32'd0);
        pc_addr = 8'hFC;
        #1;
        chk("t4_addr_fc", 32'(imem_addr), 32'd63);
        chk("t4_we_fc", {31'd0, imem_we}, 32'd0);
        pc_addr = 8'h00;

        // Reset in the middle of a load
        do_reset();
        base = wa_q.size();
        send_byte(8'h03, 0);
        send_word(32'hDEAD_BEEF);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("t5_partial_wr_count", wa_q.size() - base, 32'd1);
        chk("t5_back_in_header", {31'd0, rx_ready}, 32'd1);
        base = wa_q.size(); pb = pcr_q.size(); rb = run_q.size();
        send_byte(8'h01, 0);
        send_word(32'h1122_3344);
        wait_run("t5_run_reached");
        verify_load("t5", base, 1, 32'h1122_3344, pb, rb);

        // Reload from RUN
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        chk("t6_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t6_load_done", {31'd0, load_done}, 32'd0);
        chk("t6_rx_ready", {31'd0, rx_ready}, 32'd1);
        #1;
        base = wa_q.size(); pb = pcr_q.size(); rb = run_q.size();
        send_byte(8'h01, 0);
        send_word(32'hCAFE_F00D);
        wait_run("t6_run_reached");
        verify_load("t6", base, 1, 32'hCAFE_F00D, pb, rb);

        chk("no_we_in_run_or_err", bad_we, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the word-addressed instruction memory.
- Receives a program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into the I-mem write port.
- Zero-fills the unused tail of the memory with NOP words.
- Releases the CPU and hands I-mem addressing to the PC, replacing the hard-coded reset-time program fill.

Parameters:
DEPTH, 64, number of 32-bit I-mem words
ADDR_W, 6, word address width (log2 DEPTH)
PC_W, 8, PC byte-address width (ADDR_W+2)
DATA_W, 32, instruction width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_valid  input  1  byte available on rx_data
rx_data  input  8  program stream byte
rx_ready  output  1  loader accepts byte this cycle
reload  input  1  request a new image load (honoured in RUN only)
pc_addr  input  PC_W  CPU program counter (byte address)
imem_addr  output  ADDR_W  I-mem word address (write address while loading, read address in RUN)
imem_wdata  output  DATA_W  I-mem write data
imem_we  output  1  I-mem write enable
cpu_hold  output  1  stall CPU (PC and register writes frozen)
cpu_pc_reset  output  1  one-cycle pulse: CPU PC := 0
load_done  output  1  image resident, CPU running
err_len  output  1  sticky: illegal header length

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port named reset.
- Reset values:
  - state=HEADER, rx_ready=1, cpu_hold=1.
  - imem_we=0, imem_wdata=0, imem_addr=0.
  - cpu_pc_reset=0, load_done=0, err_len=0.
  - Byte counter and word counter cleared.
- Handshake: a byte is accepted only on a cycle with rx_valid & rx_ready. Gaps in rx_valid stall with no side effects.
- States: HEADER, LOAD, CLEAR, RUN, ERR.
- HEADER:
  - rx_ready=1. The accepted byte is N, the word count.
  - If 1<=N<=DEPTH: latch N, go to LOAD.
  - If N=0 or N>DEPTH: err_len=1, go to ERR.
- LOAD:
  - rx_ready=1. Bytes fill a shift register MSB-first: byte0 -> [31:24], byte3 -> [7:0].
  - The byte counter wraps 3 -> 0.
  - On acceptance of the 4th byte, the next cycle drives imem_we=1, imem_addr=word_idx, imem_wdata=the assembled word (registered outputs, 1-cycle latency). word_idx then increments.
  - rx_ready stays 1 during the write cycle, so back-to-back streaming is supported.
  - After word N-1 is written: go to CLEAR if N<DEPTH, else RUN.
- CLEAR:
  - rx_ready=0. One write per cycle, imem_wdata=0, addresses N..DEPTH-1 ascending.
  - Takes DEPTH-N cycles, then RUN.
- RUN:
  - cpu_hold=0, load_done=1, rx_ready=0, imem_we=0.
  - imem_addr = pc_addr[PC_W-1:2], combinational mux with zero added latency (async I-mem read path preserved).
  - cpu_pc_reset is high for exactly the first RUN cycle.
- reload=1 in RUN: next cycle HEADER, cpu_hold=1, load_done=0. Counters cleared. Memory is not cleared until the new CLEAR phase. reload is ignored in all other states.
- ERR: rx_ready=0, cpu_hold=1, err_len=1. Exit only by reset.
- Reset mid-operation (any state): partial word discarded, no write issued that cycle, returns to HEADER. Memory contents untouched by reset.
- imem_we is never asserted outside LOAD write cycles and CLEAR.
- imem_addr never exceeds DEPTH-1.

Decomposition:
- Shared package holds:
  - state enum (HEADER, LOAD, CLEAR, RUN, ERR);
  - constants DEPTH, ADDR_W, DATA_W;
  - NOP_WORD = 32'h0000_0000.
- One sub-module, imem_word_assembler: byte counter, big-endian shift register, word_valid pulse. The FSM, counters and address mux stay in the top.

Test Plan:
- Normal load: header 0x02, bytes 20 08 00 20 20 09 00 37.
  - Writes addr0=0x20080020, then addr1=0x20090037.
  - Then 62 zero writes to addr 2..63 on consecutive cycles.
  - Then load_done=1, cpu_hold=0, cpu_pc_reset high exactly 1 cycle.
- Bad length: header 0x00 -> err_len=1, rx_ready=0, cpu_hold=1, no imem_we ever. Repeat after reset with header 0x41: same response.
- Full image: header 0x40 plus 256 bytes with random rx_valid gaps.
  - 64 writes, addr 0..63, data matching the stream.
  - No CLEAR cycles; RUN on the cycle after the last write.
- RUN address mux: pc_addr=0x0C -> imem_addr=3; pc_addr=0xFC -> imem_addr=63; imem_we=0 throughout.
- Reset mid-load: header 0x03, word0 complete, 2 bytes of word1, then reset.
  - No write for the partial word.
  - A fresh header 0x01 plus 4 bytes rewrites addr0, then CLEAR covers addr 1..63.
- Reload: in RUN assert reload for 1 cycle.
  - Next cycle: cpu_hold=1, load_done=0, rx_ready=1.
  - The new image loads, and cpu_pc_reset pulses again on RUN entry.
